control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Microprogram sequencer directly upstream of the microcode control memory.
- Generates the 4-bit `control_addr` each cycle and walks the fetch routine, decode wait and per-opcode execute routine.
- Consumes the registered 10-bit control word fed back from the control memory, specifically the HLT bit (bit 9).
- Provides stall, halt and error status to the rest of the CPU.

Parameters:
- ADDR_W, 4, control memory address width.
- MEM_DEPTH, 11, number of valid microcode entries; legal addresses are 0..MEM_DEPTH-1.
- FETCH_BASE, 0, first fetch micro-address.
- FETCH_LEN, 3, fetch routine length in micro-steps (1..7).
- NOP_ADDR, 10, address of the all-zero microword; driven during wait, halt and stall-recovery states.
- DECODE_WAIT, 2, cycles between the last fetch address and sampling of `opcode` (covers memory register plus IR load).
- DISPATCH_MAP, 64'h0, packed 16x4; entry k is the start address of opcode k.
- DISPATCH_LEN, 48'h0, packed 16x3; entry k is the execute length of opcode k (0..7).

Ports:
- clk, in, 1, clock, rising edge.
- reset_control_word, in, 1, asynchronous active-high reset.
- stall, in, 1, freeze sequencer (hold state, step and `control_addr`).
- opcode, in, 4, instruction register opcode field.
- control_word, in, 10, registered word from control memory; bit 9 = HLT.
- control_addr, out, 4, registered micro-address to control memory.
- halted, out, 1, high in HALT state.
- seq_error, out, 1, sticky dispatch-range error.
- in_fetch, out, 1, high while fetch addresses are issued.
- step, out, 3, micro-step index within current routine.

Behaviour:
- Reset (asynchronous, any state, mid-routine included):
  - State FETCH; `control_addr` = FETCH_BASE; `step` = 0.
  - `halted` = 0, `seq_error` = 0, `in_fetch` = 1.
- All outputs are registered and change only on a rising clk edge.
- States: FETCH, DWAIT, EXEC, HALT.
- FETCH:
  - `control_addr` = FETCH_BASE + `step`.
  - At `step` = FETCH_LEN-1, go to DWAIT with `step` = 0; otherwise `step`++.
- DWAIT:
  - `control_addr` = NOP_ADDR; count DECODE_WAIT cycles.
  - On the last cycle, sample `opcode`; fetch start address S = DISPATCH_MAP[opcode] and length L = DISPATCH_LEN[opcode].
  - If L = 0: return to FETCH.
  - If S+L-1 > MEM_DEPTH-1 (evaluated in 5-bit arithmetic, no wrap): set `seq_error`, go to HALT.
  - Otherwise go to EXEC with `control_addr` = S and `step` = 0.
- EXEC:
  - `control_addr` = S + `step`.
  - After step L-1, go to FETCH with `control_addr` = FETCH_BASE and `step` = 0.
- HLT detection:
  - Control memory has 1-cycle latency, so `control_word` at cycle t+1 corresponds to the address issued at t.
  - When `control_word`[9] = 1 in any non-HALT state, go to HALT on that edge.
  - The address already issued for t+1 is discarded; the next `control_addr` = NOP_ADDR.
- HALT: `control_addr` = NOP_ADDR, `halted` = 1, `in_fetch` = 0. Exit only by reset. `stall` is ignored.
- Stall:
  - While `stall` = 1 (not in HALT), state, `step` and `control_addr` hold.
  - HLT is still honoured during stall.
  - Deassertion resumes on the next edge with no step skipped or repeated.
- Simultaneous events:
  - Reset overrides everything.
  - HLT overrides stall, routine end and dispatch.
  - A dispatch error in the same cycle as HLT: `seq_error` is still set, and the block goes to HALT.
- `step` width is 3 bits. Lengths above 7 are impossible by parameter width; no wrap occurs.
- `seq_error` clears only on reset.

Test Plan:
- Reset, run with `opcode` = 2, DISPATCH_MAP[2] = 4, DISPATCH_LEN[2] = 2 -> `control_addr` sequence 0,1,2,10,10,4,5,0,1 and `in_fetch` high for the first 3 cycles.
- `control_word` = 10'b1000000000 returned one cycle after address 5 is issued -> next `control_addr` = 10 and `halted` = 1; it stays so for 20 cycles regardless of `stall`/`opcode`.
- `opcode` with DISPATCH_LEN = 0 -> after DWAIT, `control_addr` returns to 0 with no EXEC cycles.
- `opcode` mapped to start 9, length 3 (end 11 > 10) -> `seq_error` = 1, `halted` = 1, `control_addr` = 10; reset clears both.
- `stall` asserted for 3 cycles while `control_addr` = 1 in FETCH -> `control_addr` holds 1 for 4 cycles, then continues 2,10.
- Assert reset asynchronously mid-EXEC (between edges) -> `control_addr` = 0, `step` = 0 and `halted` = 0 immediately; normal fetch resumes after release.

Source files
------------

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Microprogram sequencer sitting directly in front of the microcode control
// memory. Each cycle it issues a registered micro-address: it walks the fetch
// routine, idles on the NOP word while the instruction register settles, then
// dispatches to the per-opcode execute routine through DISPATCH_MAP and
// DISPATCH_LEN. The HLT bit of the registered control word coming back from
// the memory stops the machine until reset.
//
// Ports
//   clk                 in   rising-edge clock
//   reset_control_word  in   asynchronous active-high reset
//   stall               in   hold state, step and control_addr
//   opcode[3:0]         in   instruction register opcode field
//   control_word[9:0]   in   registered control memory word, bit 9 = HLT
//   control_addr        out  registered micro-address to control memory
//   halted              out  high in HALT
//   seq_error           out  sticky dispatch-range error
//   in_fetch            out  high while fetch addresses are issued
//   step[2:0]           out  micro-step index within the current routine
// ---------------------------------------------------------------------------
module control_sequencer #(
    parameter int          ADDR_W       = 4,
    parameter int          MEM_DEPTH    = 11,
    parameter int          FETCH_BASE   = 0,
    parameter int          FETCH_LEN    = 3,
    parameter int          NOP_ADDR     = 10,
    parameter int          DECODE_WAIT  = 2,
    parameter logic [63:0] DISPATCH_MAP = 64'h0,
    parameter logic [47:0] DISPATCH_LEN = 48'h0
) (
    input  logic              clk,
    input  logic              reset_control_word,
    input  logic              stall,
    input  logic [3:0]        opcode,
    input  logic [9:0]        control_word,
    output logic [ADDR_W-1:0] control_addr,
    output logic              halted,
    output logic              seq_error,
    output logic              in_fetch,
    output logic [2:0]        step
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DWAIT = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam int                WAIT_W       = (DECODE_WAIT > 1) ? $clog2(DECODE_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST    = WAIT_W'(DECODE_WAIT - 1);
    localparam logic [ADDR_W-1:0] FETCH_BASE_A = ADDR_W'(FETCH_BASE);
    localparam logic [ADDR_W-1:0] NOP_A        = ADDR_W'(NOP_ADDR);
    localparam logic [2:0]        FETCH_LAST   = 3'(FETCH_LEN - 1);
    localparam logic [4:0]        ADDR_MAX     = 5'(MEM_DEPTH - 1);

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_addr, w_addr_next;
    logic [2:0]          r_step, w_step_next;
    logic [WAIT_W-1:0]   r_wait, w_wait_next;
    logic [ADDR_W-1:0]   r_exec_base, w_exec_base_next;
    logic [2:0]          r_exec_len, w_exec_len_next;
    logic                r_err, w_err_next;
    logic                r_halted;
    logic                r_in_fetch;

    // Unpack the dispatch tables once so the opcode lookup is a plain mux.
    logic [3:0] w_map [16];
    logic [2:0] w_len [16];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_disp
            assign w_map[gi] = DISPATCH_MAP[gi*4 +: 4];
            assign w_len[gi] = DISPATCH_LEN[gi*3 +: 3];
        end
    endgenerate

    logic [ADDR_W-1:0] w_disp_start;
    logic [2:0]        w_disp_len;
    logic [4:0]        w_disp_end;
    logic              w_disp_bad;
    logic              w_dispatch;
    logic              w_hlt;
    logic [2:0]        w_step_inc;
    logic              w_unused_cw;

    assign w_disp_start = ADDR_W'(w_map[opcode]);
    assign w_disp_len   = w_len[opcode];
    // Five bits so that start 15 + length 7 cannot wrap back into range.
    assign w_disp_end   = 5'(w_map[opcode]) + 5'(w_disp_len) - 5'd1;
    assign w_disp_bad   = (w_disp_len != 3'd0) && (w_disp_end > ADDR_MAX);
    assign w_dispatch   = (r_state == S_DWAIT) && (r_wait == WAIT_LAST);
    assign w_hlt        = control_word[9] && (r_state != S_HALT);
    assign w_step_inc   = r_step + 3'd1;
    // Only the HLT bit matters here; the rest of the word drives the datapath.
    assign w_unused_cw  = ^control_word[8:0];

    always_comb begin
        w_state_next     = r_state;
        w_addr_next      = r_addr;
        w_step_next      = r_step;
        w_wait_next      = r_wait;
        w_exec_base_next = r_exec_base;
        w_exec_len_next  = r_exec_len;
        w_err_next       = r_err;

        // A bad dispatch is flagged even when HLT wins the same edge; a plain
        // stall merely postpones the dispatch decision.
        if (w_dispatch && w_disp_bad && (w_hlt || !stall)) begin
            w_err_next = 1'b1;
        end

        if (r_state == S_HALT) begin
            w_state_next = S_HALT;
        end else if (w_hlt) begin
            // The address already issued for the next cycle is dropped.
            w_state_next = S_HALT;
            w_addr_next  = NOP_A;
            w_step_next  = 3'd0;
        end else if (!stall) begin
            case (r_state)
                S_FETCH: begin
                    if (r_step == FETCH_LAST) begin
                        w_state_next = S_DWAIT;
                        w_addr_next  = NOP_A;
                        w_step_next  = 3'd0;
                        w_wait_next  = '0;
                    end else begin
                        w_step_next = w_step_inc;
                        w_addr_next = FETCH_BASE_A + ADDR_W'(w_step_inc);
                    end
                end
                S_DWAIT: begin
                    if (w_dispatch) begin
                        if (w_disp_len == 3'd0) begin
                            w_state_next = S_FETCH;
                            w_addr_next  = FETCH_BASE_A;
                            w_step_next  = 3'd0;
                        end else if (w_disp_bad) begin
                            w_state_next = S_HALT;
                            w_addr_next  = NOP_A;
                            w_step_next  = 3'd0;
                        end else begin
                            w_state_next     = S_EXEC;
                            w_addr_next      = w_disp_start;
                            w_step_next      = 3'd0;
                            w_exec_base_next = w_disp_start;
                            w_exec_len_next  = w_disp_len;
                        end
                    end else begin
                        w_wait_next = r_wait + WAIT_W'(1);
                    end
                end
                S_EXEC: begin
                    if (r_step == r_exec_len - 3'd1) begin
                        w_state_next = S_FETCH;
                        w_addr_next  = FETCH_BASE_A;
                        w_step_next  = 3'd0;
                    end else begin
                        w_step_next = w_step_inc;
                        w_addr_next = r_exec_base + ADDR_W'(w_step_inc);
                    end
                end
                default: begin
                    w_state_next = S_HALT;
                    w_addr_next  = NOP_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_control_word) begin
        if (reset_control_word) begin
            r_state     <= S_FETCH;
            r_addr      <= FETCH_BASE_A;
            r_step      <= 3'd0;
            r_wait      <= '0;
            r_exec_base <= '0;
            r_exec_len  <= 3'd0;
            r_err       <= 1'b0;
            r_halted    <= 1'b0;
            r_in_fetch  <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_addr      <= w_addr_next;
            r_step      <= w_step_next;
            r_wait      <= w_wait_next;
            r_exec_base <= w_exec_base_next;
            r_exec_len  <= w_exec_len_next;
            r_err       <= w_err_next;
            r_halted    <= (w_state_next == S_HALT);
            r_in_fetch  <= (w_state_next == S_FETCH);
        end
    end

    assign control_addr = r_addr;
    assign halted       = r_halted;
    assign seq_error    = r_err;
    assign in_fetch     = r_in_fetch;
    assign step         = r_step;

endmodule
